// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: takes an N-bit word over valid/ready,
// then shifts it out one bit per shift_en strobe with frame-active and done flags.
module piso_serializer #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    input  logic         shift_en,
    output logic         s_out,
    output logic         s_valid,
    output logic         done
);

    localparam int            CW   = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   shreg, shreg_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic           done_r, done_nxt;
    logic           head_bit;
    logic [N-1:0]   shreg_adv;

    // Bit on the wire and the zero-filled advance, both fixed by bit order.
    generate
        if (MSB_FIRST) begin : g_msb
            assign head_bit  = shreg[N-1];
            assign shreg_adv = {shreg[N-2:0], 1'b0};
        end else begin : g_lsb
            assign head_bit  = shreg[0];
            assign shreg_adv = {1'b0, shreg[N-1:1]};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            shreg  <= shreg_nxt;
            cnt    <= cnt_nxt;
            done_r <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_nxt = in_data;
                    cnt_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (cnt == LAST) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        shreg_nxt = shreg_adv;
                        cnt_nxt   = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign s_valid  = (state == SHIFT);
    assign s_out    = s_valid & head_bit;
    assign done     = done_r;

endmodule
